// File: rtl/spi_xfer_sequencer.sv
// Sequences 3-byte SPI transactions for two round-robin requesters: chip-select
// setup, three byte exchanges through an external SPI byte master, hold, ack.
module spi_xfer_sequencer #(
   parameter int CS_SETUP = 4,
   parameter int CS_HOLD  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic [23:0] wdata0,
   input  logic [23:0] wdata1,
   output logic        ack0,
   output logic        ack1,
   output logic [23:0] rdata0,
   output logic [23:0] rdata1,
   output logic        spi_rw_req,
   output logic [7:0]  spi_wr_data,
   input  logic [7:0]  spi_rd_data,
   input  logic        spi_rd_strobe,
   input  logic        spi_ready,
   output logic        cs_n,
   output logic        busy
);

   typedef enum logic [2:0] {IDLE, SETUP, SEND, WAIT, HOLD, DONE} state_t;

   localparam logic [7:0] SETUP_LD = 8'(CS_SETUP);
   localparam logic [7:0] HOLD_LD  = 8'(CS_HOLD);

   state_t      state;
   logic [23:0] tx_sr;
   logic [23:0] rx_sr;
   logic [7:0]  setup_cnt;
   logic [7:0]  hold_cnt;
   logic [1:0]  byte_cnt;
   logic        grant;
   logic        last_grant;
   logic        pick1;

   // req1 wins when alone, or on a tie when req0 was served last
   assign pick1 = req1 & (~req0 | ~last_grant);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cs_n        <= 1'b1;
         busy        <= 1'b0;
         spi_rw_req  <= 1'b0;
         spi_wr_data <= 8'h00;
         ack0        <= 1'b0;
         ack1        <= 1'b0;
         rdata0      <= 24'h0;
         rdata1      <= 24'h0;
         tx_sr       <= 24'h0;
         rx_sr       <= 24'h0;
         setup_cnt   <= 8'h00;
         hold_cnt    <= 8'h00;
         byte_cnt    <= 2'd0;
         grant       <= 1'b0;
         last_grant  <= 1'b1;
      end else begin
         spi_rw_req <= 1'b0;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 | req1) begin
                  grant     <= pick1;
                  tx_sr     <= pick1 ? wdata1 : wdata0;
                  byte_cnt  <= 2'd3;
                  cs_n      <= 1'b0;
                  busy      <= 1'b1;
                  setup_cnt <= SETUP_LD;
                  state     <= SETUP;
               end
            end
            SETUP: begin
               if (setup_cnt <= 8'd1) state <= SEND;
               else                   setup_cnt <= setup_cnt - 8'd1;
            end
            SEND: begin
               if (spi_ready) begin
                  spi_rw_req  <= 1'b1;
                  spi_wr_data <= tx_sr[23:16];
                  tx_sr       <= {tx_sr[15:0], 8'h00};
                  state       <= WAIT;
               end
            end
            WAIT: begin
               if (spi_rd_strobe) begin
                  rx_sr    <= {rx_sr[15:0], spi_rd_data};
                  byte_cnt <= byte_cnt - 2'd1;
                  if (byte_cnt > 2'd1) begin
                     state <= SEND;
                  end else begin
                     hold_cnt <= HOLD_LD;
                     state    <= HOLD;
                  end
               end
            end
            HOLD: begin
               // ack and rdata are registered on the way into DONE so both are
               // visible during the single DONE cycle
               if (hold_cnt <= 8'd1) begin
                  cs_n  <= 1'b1;
                  ack0  <= ~grant;
                  ack1  <= grant;
                  if (grant) rdata1 <= rx_sr;
                  else       rdata0 <= rx_sr;
                  state <= DONE;
               end else begin
                  hold_cnt <= hold_cnt - 8'd1;
               end
            end
            DONE: begin
               last_grant <= grant;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/spi_xfer_sequencer.md
SPI_XFER_SEQUENCER -- requirements
Module: spi_xfer_sequencer

Interface
REQ-001 Parameter: CS_SETUP, default 4, cycles with cs_n low before the first byte request; legal range 1..255.
REQ-002 Parameter: CS_HOLD, default 4, cycles after the last byte's rd_strobe before cs_n rises; legal range 1..255.
REQ-003 clk  in  1  sole clock; every flop on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req0 / req1  in  1  requester transaction request; level, held high until the matching ack.
REQ-006 wdata0 / wdata1  in  24  3-byte transmit word; byte order [23:16], then [15:8], then [7:0].
REQ-007 ack0 / ack1  out  1  one-cycle completion pulse to the requester.
REQ-008 rdata0 / rdata1  out  24  received bytes, first byte in [23:16]; valid in the ack cycle and held until that requester's next ack.
REQ-009 spi_rw_req  out  1  one-cycle byte request to the SPI byte master.
REQ-010 spi_wr_data  out  8  byte to transmit; valid in the spi_rw_req cycle.
REQ-011 spi_rd_data  in  8  received byte from the SPI byte master; valid when spi_rd_strobe is high.
REQ-012 spi_rd_strobe  in  1  byte-complete pulse from the SPI byte master.
REQ-013 spi_ready  in  1  SPI byte master idle.
REQ-014 cs_n  out  1  device chip select, active low.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 The block SHALL implement the states IDLE, SETUP, SEND, WAIT, HOLD and DONE.
REQ-017 IDLE: if any req is high, the block SHALL latch the granted wdata, set byte_cnt=3, drive cs_n=0, load the setup counter and move to SETUP.
REQ-018 Arbitration SHALL be round-robin: with both reqs high, grant the requester not granted last; reset state makes req0 win the first tie.
REQ-019 SETUP SHALL hold for exactly CS_SETUP cycles, then move to SEND.
REQ-020 SEND: when spi_ready=1, the block SHALL pulse spi_rw_req for one cycle with the current MSB byte on spi_wr_data, shift the tx register left by 8 and move to WAIT; while spi_ready=0 it SHALL stay in SEND.
REQ-021 WAIT: on spi_rd_strobe, the block SHALL shift spi_rd_data into the low byte of the rx register and decrement byte_cnt; it then goes to SEND if byte_cnt was above 1, otherwise to HOLD.
REQ-022 spi_rd_strobe SHALL be ignored in every state except WAIT; spi_rw_req SHALL never be asserted outside SEND.
REQ-023 HOLD SHALL last exactly CS_HOLD cycles, then drive cs_n=1 and move to DONE.
REQ-024 DONE SHALL last one cycle: pulse the granted requester's ack, load its rdata with rx, update the last-grant pointer and return to IDLE.
REQ-025 cs_n SHALL stay high for at least one IDLE cycle between transactions, even with requests pending.
REQ-026 If a req deasserts mid-transaction, the transaction SHALL complete unchanged and its ack SHALL still pulse.
REQ-027 A change of wdata after grant SHALL have no effect on the current transaction.
REQ-028 The setup and hold counters SHALL be 8 bits wide and byte_cnt 2 bits wide, with no wrap-around in legal operation.

Reset
REQ-029 reset SHALL force: state IDLE, cs_n=1, spi_rw_req=0, spi_wr_data=0, ack0=ack1=0, rdata0=rdata1=0, busy=0, last grant = req1.
REQ-030 Reset asserted mid-transaction SHALL abort it with no ack; cs_n=1 and spi_rw_req=0 SHALL hold from the first clock edge with reset high.
REQ-031 The SPI byte master SHALL be reset in the same cycle as this block.

Verification
REQ-032 Single transfer: req0=1, wdata0=0xA5_3C_0F, loopback MISO -> cs_n low CS_SETUP cycles, then bytes A5, 3C, 0F, then CS_HOLD cycles; ack0 pulses once with rdata0=0xA53C0F.
REQ-033 Tie: req0 and req1 rise in the same cycle, both held for two transactions -> grant order req0, req1; cs_n high at least 1 cycle between them; exactly one ack each.
REQ-034 Stalled master: spi_ready held 0 for 20 cycles in SEND -> no spi_rw_req until spi_ready=1; byte order unchanged.
REQ-035 Reset during WAIT of byte 2 -> next edge cs_n=1, busy=0, no ack; a fresh req1 afterwards completes normally.
REQ-036 Spurious spi_rd_strobe in IDLE and SETUP -> rx register and byte_cnt unchanged; the next transaction returns the correct 24-bit data.
